fc_result_argmax: RTL and testbench

Downstream consumer of the fully-connected layer's output write port. It captures the NUM_OUT signed 32-bit FC results into a local buffer as they are written, indexed by write address. When the FC core signals done, it performs a sequential signed argmax scan. It then presents the winning class index and value, plus a completeness flag and a registered random-read port for host/AXI readback.

---
 rtl/fc_result_argmax_if.sv | 32 +++
 rtl/fc_result_argmax.sv | 145 ++++++++++++++
 tb/tb_fc_result_argmax.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fc_result_argmax_if.sv
// Bundle of the FC result capture / argmax ports: FC write side, done pulse,
// host readback and result status.
interface fc_result_argmax_if #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32
);
   logic              start_i;
   logic              wr_en_i;
   logic [ADDR_W-1:0] wr_addr_i;
   logic [DATA_W-1:0] wr_data_i;
   logic              fc_done_i;
   logic [ADDR_W-1:0] rd_addr_i;
   logic [DATA_W-1:0] rd_data_o;
   logic              busy_o;
   logic              result_valid_o;
   logic [ADDR_W-1:0] max_idx_o;
   logic [DATA_W-1:0] max_val_o;
   logic [ADDR_W:0]   wr_cnt_o;
   logic              incomplete_o;

   modport master (
      output start_i, wr_en_i, wr_addr_i, wr_data_i, fc_done_i, rd_addr_i,
      input  rd_data_o, busy_o, result_valid_o, max_idx_o, max_val_o,
             wr_cnt_o, incomplete_o
   );

   modport slave (
      input  start_i, wr_en_i, wr_addr_i, wr_data_i, fc_done_i, rd_addr_i,
      output rd_data_o, busy_o, result_valid_o, max_idx_o, max_val_o,
             wr_cnt_o, incomplete_o
   );
endinterface

// File: rtl/fc_result_argmax.sv
// Captures FC layer outputs into a local buffer, then runs a sequential signed
// argmax scan once the FC core reports done; buffer is readable by the host.
module fc_result_argmax #(
   parameter int NUM_OUT = 128,
   parameter int ADDR_W  = 7,
   parameter int DATA_W  = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   fc_result_argmax_if.slave        bus
);

   localparam logic [ADDR_W:0]   NUM_OUT_C = (ADDR_W+1)'(NUM_OUT);
   localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SCAN, S_RESULT} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] mem_q [NUM_OUT];
   logic [NUM_OUT-1:0] written_q, written_d;
   logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
   logic [ADDR_W:0]   scan_idx_q, scan_idx_d;
   logic [ADDR_W-1:0] max_idx_q, max_idx_d;
   logic [DATA_W-1:0] max_val_q, max_val_d;
   logic              found_q, found_d;
   logic              pipe_vld_q, pipe_vld_d;
   logic              pipe_hit_q, pipe_hit_d;
   logic [ADDR_W-1:0] pipe_idx_q, pipe_idx_d;
   logic [DATA_W-1:0] scan_data_q, scan_data_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              wr_ok;
   logic              wr_in_range;
   logic              rd_in_range;

   assign wr_in_range = ({1'b0, bus.wr_addr_i} < NUM_OUT_C);
   assign rd_in_range = ({1'b0, bus.rd_addr_i} < NUM_OUT_C);

   always_comb begin
      rd_data_d   = rd_in_range ? mem_q[bus.rd_addr_i] : '0;
      scan_data_d = mem_q[scan_idx_q[ADDR_W-1:0]];
   end

   // Scan is a two-stage pipe: issue read of entry i, compare it one cycle
   // later. This gives the done-to-result latency of NUM_OUT+1 edges.
   always_comb begin
      state_d    = state_q;
      written_d  = written_q;
      wr_cnt_d   = wr_cnt_q;
      scan_idx_d = scan_idx_q;
      max_idx_d  = max_idx_q;
      max_val_d  = max_val_q;
      found_d    = found_q;
      pipe_vld_d = 1'b0;
      pipe_hit_d = 1'b0;
      pipe_idx_d = pipe_idx_q;
      wr_ok      = 1'b0;

      if (bus.start_i) begin
         state_d    = S_COLLECT;
         written_d  = '0;
         wr_cnt_d   = '0;
         scan_idx_d = '0;
         max_idx_d  = '0;
         max_val_d  = '0;
         found_d    = 1'b0;
      end else begin
         unique case (state_q)
            S_COLLECT: begin
               if (bus.wr_en_i && wr_in_range) begin
                  wr_ok = 1'b1;
                  if (!written_q[bus.wr_addr_i]) begin
                     written_d[bus.wr_addr_i] = 1'b1;
                     wr_cnt_d = wr_cnt_q + 1'b1;
                  end
               end
               if (bus.fc_done_i) begin
                  state_d    = S_SCAN;
                  scan_idx_d = '0;
               end
            end
            S_SCAN: begin
               if (scan_idx_q < NUM_OUT_C) begin
                  pipe_vld_d = 1'b1;
                  pipe_idx_d = scan_idx_q[ADDR_W-1:0];
                  pipe_hit_d = written_q[scan_idx_q[ADDR_W-1:0]];
                  scan_idx_d = scan_idx_q + 1'b1;
               end
               if (pipe_vld_q) begin
                  if (pipe_hit_q &&
                      (!found_q || ($signed(scan_data_q) > $signed(max_val_q)))) begin
                     found_d   = 1'b1;
                     max_idx_d = pipe_idx_q;
                     max_val_d = scan_data_q;
                  end
                  if (pipe_idx_q == LAST_C) state_d = S_RESULT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         written_q   <= '0;
         wr_cnt_q    <= '0;
         scan_idx_q  <= '0;
         max_idx_q   <= '0;
         max_val_q   <= '0;
         found_q     <= 1'b0;
         pipe_vld_q  <= 1'b0;
         pipe_hit_q  <= 1'b0;
         pipe_idx_q  <= '0;
         scan_data_q <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         written_q   <= written_d;
         wr_cnt_q    <= wr_cnt_d;
         scan_idx_q  <= scan_idx_d;
         max_idx_q   <= max_idx_d;
         max_val_q   <= max_val_d;
         found_q     <= found_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_hit_q  <= pipe_hit_d;
         pipe_idx_q  <= pipe_idx_d;
         scan_data_q <= scan_data_d;
         rd_data_q   <= rd_data_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok && !rst_i) mem_q[bus.wr_addr_i] <= bus.wr_data_i;
   end

   assign bus.rd_data_o      = rd_data_q;
   assign bus.busy_o         = (state_q == S_COLLECT) || (state_q == S_SCAN);
   assign bus.result_valid_o = (state_q == S_RESULT);
   assign bus.max_idx_o      = max_idx_q;
   assign bus.max_val_o      = max_val_q;
   assign bus.wr_cnt_o       = wr_cnt_q;
   assign bus.incomplete_o   = (state_q == S_RESULT) && (wr_cnt_q != NUM_OUT_C);

endmodule

// File: tb/tb_fc_result_argmax.sv
// Directed bench for fc_result_argmax: expected results queued at fc_done,
// checked by a monitor when result_valid_o rises.
module tb_fc_result_argmax;

   typedef struct {
      logic [6:0]  idx;
      logic [31:0] val;
      logic [7:0]  cnt;
      logic        inc;
      int          done_edge;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   logic prev_rv = 1'b0;

   fc_result_argmax_if #(.ADDR_W(7), .DATA_W(32)) bus ();

   fc_result_argmax #(.NUM_OUT(128), .ADDR_W(7), .DATA_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: compare every rising result_valid_o against the queued expectation.
   always @(negedge clk) begin
      if (bus.result_valid_o && !prev_rv) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("max_idx", 32'(bus.max_idx_o), 32'(e.idx));
            chk("max_val", bus.max_val_o, e.val);
            chk("wr_cnt", 32'(bus.wr_cnt_o), 32'(e.cnt));
            chk("incomplete", 32'(bus.incomplete_o), 32'(e.inc));
            chk("latency", 32'(cyc - e.done_edge), 32'd129);
         end
      end
      prev_rv = bus.result_valid_o;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_start();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d);
      bus.wr_en_i   = 1'b1;
      bus.wr_addr_i = a;
      bus.wr_data_i = d;
      step();
      bus.wr_en_i = 1'b0;
   endtask

   // Pulse fc_done (optionally with a same-cycle write); queue expectation if given.
   task automatic done(input bit push, input exp_t e, input bit with_wr,
                       input logic [6:0] a, input logic [31:0] d);
      exp_t ee;
      ee = e;
      ee.done_edge = cyc + 1;
      if (push) exp_q.push_back(ee);
      bus.fc_done_i = 1'b1;
      if (with_wr) begin
         bus.wr_en_i   = 1'b1;
         bus.wr_addr_i = a;
         bus.wr_data_i = d;
      end
      step();
      bus.fc_done_i = 1'b0;
      bus.wr_en_i   = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("result_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic rd(input string name, input logic [6:0] a, input logic [31:0] req);
      bus.rd_addr_i = a;
      step();
      chk(name, bus.rd_data_o, req);
   endtask

   initial begin
      exp_t e;
      bus.start_i   = 1'b0;
      bus.wr_en_i   = 1'b0;
      bus.wr_addr_i = '0;
      bus.wr_data_i = '0;
      bus.fc_done_i = 1'b0;
      bus.rd_addr_i = '0;
      step(); step();
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_valid", 32'(bus.result_valid_o), 32'd0);
      chk("rst_rd_data", bus.rd_data_o, 32'd0);
      rst = 1'b0;
      step();

      // 1: ascending values, max at the last index
      do_start();
      for (int k = 0; k < 128; k++) wr(7'(k), 32'(k - 64));
      e = '{idx: 7'd127, val: 32'd63, cnt: 8'd128, inc: 1'b0, done_edge: 0};
      done(1'b1, e, 1'b0, '0, '0);
      wait_drain();

      // 2: tie between 40 and 90, most negative at 3; read-during-write returns old
      do_start();
      bus.rd_addr_i = 7'd0;
      wr(7'd0, 32'hFFFF_FFFB);
      chk("rdw_old_data", bus.rd_data_o, 32'hFFFF_FFC0);
      for (int k = 1; k < 128; k++) begin
         if (k == 40 || k == 90) wr(7'(k), 32'h7FFF_FFFF);
         else if (k == 3)        wr(7'(k), 32'h8000_0000);
         else                    wr(7'(k), 32'hFFFF_FFFB);
      end
      rd("rd_after_write", 7'd0, 32'hFFFF_FFFB);
      e = '{idx: 7'd40, val: 32'h7FFF_FFFF, cnt: 8'd128, inc: 1'b0, done_edge: 0};
      done(1'b1, e, 1'b0, '0, '0);
      wait_drain();
      rd("rd_addr3", 7'd3, 32'h8000_0000);

      // 3a: sparse writes with a rewrite
      do_start();
      wr(7'd10, 32'hFFFF_FF9C);
      wr(7'd20, 32'hFFFF_FF38);
      wr(7'd10, 32'hFFFF_FF9C);
      e = '{idx: 7'd10, val: 32'hFFFF_FF9C, cnt: 8'd2, inc: 1'b1, done_edge: 0};
      done(1'b1, e, 1'b0, '0, '0);
      wait_drain();
      // 3b: nothing written
      do_start();
      e = '{idx: 7'd0, val: 32'd0, cnt: 8'd0, inc: 1'b1, done_edge: 0};
      done(1'b1, e, 1'b0, '0, '0);
      wait_drain();

      // 4: last write coincides with fc_done; later writes are ignored
      do_start();
      for (int k = 0; k < 127; k++) wr(7'(k), 32'd0);
      e = '{idx: 7'd127, val: 32'd1000, cnt: 8'd128, inc: 1'b0, done_edge: 0};
      done(1'b1, e, 1'b1, 7'd127, 32'd1000);
      wr(7'd127, 32'd5000);
      wait_drain();
      wr(7'd127, 32'd6000);
      rd("rd_after_done", 7'd127, 32'd1000);

      // 5: abort the scan with start_i, then a fresh run (peak at index 60)
      do_start();
      for (int k = 0; k < 128; k++) wr(7'(k), 32'(k));
      done(1'b0, e, 1'b0, '0, '0);
      for (int k = 0; k < 48; k++) step();
      do_start();
      chk("abort_busy", 32'(bus.busy_o), 32'd1);
      chk("abort_valid", 32'(bus.result_valid_o), 32'd0);
      chk("abort_wr_cnt", 32'(bus.wr_cnt_o), 32'd0);
      for (int k = 0; k < 128; k++) wr(7'(k), 32'(1000 - (k - 60) * (k - 60)));
      e = '{idx: 7'd60, val: 32'd1000, cnt: 8'd128, inc: 1'b0, done_edge: 0};
      done(1'b1, e, 1'b0, '0, '0);
      wait_drain();

      // 6: reset mid-collect with start_i and a write both high
      do_start();
      wr(7'd5, 32'h1234_5678);
      wr(7'd6, 32'd9);
      rst = 1'b1;
      bus.start_i = 1'b1;
      bus.wr_en_i = 1'b1;
      bus.wr_addr_i = 7'd5;
      bus.wr_data_i = 32'hDEAD_BEEF;
      step();
      rst = 1'b0;
      bus.start_i = 1'b0;
      bus.wr_en_i = 1'b0;
      chk("rst6_busy", 32'(bus.busy_o), 32'd0);
      chk("rst6_valid", 32'(bus.result_valid_o), 32'd0);
      chk("rst6_max_idx", 32'(bus.max_idx_o), 32'd0);
      chk("rst6_max_val", bus.max_val_o, 32'd0);
      chk("rst6_wr_cnt", 32'(bus.wr_cnt_o), 32'd0);
      chk("rst6_incomplete", 32'(bus.incomplete_o), 32'd0);
      chk("rst6_rd_data", bus.rd_data_o, 32'd0);
      wr(7'd5, 32'h0000_0BAD);
      chk("idle_busy", 32'(bus.busy_o), 32'd0);
      rd("rd_addr5", 7'd5, 32'h1234_5678);

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
